// File: rtl/ab_cogrant_arbiter_pkg.sv
// Shared types for the A/B co-grant arbiter: FSM states, round-robin side
// and the cool-down counter width.
package ab_arb_pkg;

    typedef enum logic [1:0] {
        OPEN,
        DUAL,
        COOL
    } arb_state_t;

    typedef enum logic {
        SIDE_A,
        SIDE_B
    } rr_side_t;

    localparam int unsigned COOL_W = 4;

endpackage

// File: rtl/ab_cogrant_arbiter_if.sv
// Request/grant bundle between the two requesters and the arbiter.
interface ab_cogrant_arbiter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             req_a;
    logic             req_b;
    logic             signal_a;
    logic             signal_b;
    logic             cool_active;
    logic [CNT_W-1:0] dual_cnt;

    modport master (
        output en, req_a, req_b,
        input  signal_a, signal_b, cool_active, dual_cnt
    );

    modport slave (
        input  en, req_a, req_b,
        output signal_a, signal_b, cool_active, dual_cnt
    );
endinterface

// File: rtl/ab_cogrant_arbiter_cool_timer.sv
// Loadable down-counter timing the window after a dual grant.
module ab_cool_timer
    import ab_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [COOL_W-1:0] load_val,
    output logic [COOL_W-1:0] cnt,
    output logic              active
);

    logic [COOL_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - COOL_W'(1);
        end
    end

    assign cnt    = r_cnt;
    assign active = (r_cnt != '0);

endmodule

// File: rtl/ab_cogrant_arbiter.sv
// Two-requester arbiter allowing a single-cycle dual grant, followed by a
// round-robin cool-down window of COOL_CYCLES cycles.
module ab_cogrant_arbiter
    import ab_arb_pkg::*;
#(
    parameter int unsigned COOL_CYCLES = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ab_cogrant_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    rr_side_t          r_rr;
    rr_side_t          w_rr_nxt;
    logic              r_sig_a;
    logic              r_sig_b;
    logic [CNT_W-1:0]  r_dual_cnt;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_dual;
    logic [COOL_W-1:0] w_cool_cnt;
    logic              w_cool_active;

    ab_cool_timer u_cool_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_dual),
        .load_val (COOL_W'(COOL_CYCLES)),
        .cnt      (w_cool_cnt),
        .active   (w_cool_active)
    );

    // OPEN is exactly "cool counter is zero", so it gates the dual grant.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        w_dual    = 1'b0;
        w_rr_nxt  = r_rr;
        if (bus.en) begin
            if (bus.req_a && bus.req_b) begin
                if (r_state == OPEN) begin
                    w_grant_a = 1'b1;
                    w_grant_b = 1'b1;
                    w_dual    = 1'b1;
                end else begin
                    w_grant_a = (r_rr == SIDE_A);
                    w_grant_b = (r_rr == SIDE_B);
                    w_rr_nxt  = (r_rr == SIDE_A) ? SIDE_B : SIDE_A;
                end
            end else begin
                w_grant_a = bus.req_a;
                w_grant_b = bus.req_b;
            end
        end
    end

    // Counter reaches zero on this edge when it currently holds 0 or 1.
    always_comb begin
        w_state_nxt = OPEN;
        if (w_dual) begin
            w_state_nxt = DUAL;
        end else if (w_cool_cnt > COOL_W'(1)) begin
            w_state_nxt = COOL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= OPEN;
            r_rr       <= SIDE_A;
            r_sig_a    <= 1'b0;
            r_sig_b    <= 1'b0;
            r_dual_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_sig_a <= w_grant_a;
            r_sig_b <= w_grant_b;
            if (w_dual && (r_dual_cnt != '1)) begin
                r_dual_cnt <= r_dual_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.signal_a    = r_sig_a;
    assign bus.signal_b    = r_sig_b;
    assign bus.cool_active = w_cool_active;
    assign bus.dual_cnt    = r_dual_cnt;

endmodule

// File: tb/tb_ab_cogrant_arbiter.sv
// Directed bench for ab_cogrant_arbiter: three instances with different
// COOL_CYCLES/CNT_W, idle ones held in reset while another is exercised.
module tb_ab_cogrant_arbiter;

    typedef struct {
        logic       en;
        logic       ra;
        logic       rb;
        logic       ea;
        logic       eb;
        logic       ecool;
        logic [7:0] edcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst1, rst2, rst3;
    logic en, req_a, req_b;
    int   sel;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       o_a, o_b, o_cool;
    logic [7:0] o_dcnt;

    always #5 clk = ~clk;

    ab_cogrant_arbiter_if #(.CNT_W(2)) if1 ();
    ab_cogrant_arbiter_if #(.CNT_W(8)) if2 ();
    ab_cogrant_arbiter_if #(.CNT_W(8)) if3 ();

    assign if1.en = en;  assign if1.req_a = req_a;  assign if1.req_b = req_b;
    assign if2.en = en;  assign if2.req_a = req_a;  assign if2.req_b = req_b;
    assign if3.en = en;  assign if3.req_a = req_a;  assign if3.req_b = req_b;

    ab_cogrant_arbiter #(.COOL_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset_n(rst1), .bus(if1.slave)
    );
    ab_cogrant_arbiter #(.COOL_CYCLES(2), .CNT_W(8)) dut2 (
        .clk(clk), .reset_n(rst2), .bus(if2.slave)
    );
    ab_cogrant_arbiter #(.COOL_CYCLES(3), .CNT_W(8)) dut3 (
        .clk(clk), .reset_n(rst3), .bus(if3.slave)
    );

    always_comb begin
        o_a = 1'b0; o_b = 1'b0; o_cool = 1'b0; o_dcnt = '0;
        case (sel)
            1: begin o_a = if1.signal_a; o_b = if1.signal_b; o_cool = if1.cool_active; o_dcnt = 8'(if1.dual_cnt); end
            2: begin o_a = if2.signal_a; o_b = if2.signal_b; o_cool = if2.cool_active; o_dcnt = if2.dual_cnt; end
            default: begin o_a = if3.signal_a; o_b = if3.signal_b; o_cool = if3.cool_active; o_dcnt = if3.dual_cnt; end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic a, input logic b);
        en = e; req_a = a; req_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string name, input logic [1:0] exp);
        chk(name, {30'b0, o_a, o_b}, {30'b0, exp});
    endtask

    function automatic vec_t mk(input logic [5:0] bits, input int d);
        vec_t v;
        {v.en, v.ra, v.rb, v.ea, v.eb, v.ecool} = bits;
        v.edcnt = 8'(d);
        return v;
    endfunction

    vec_t        tbl[$];
    logic [1:0]  pat1 [9];
    logic        prev_dual;

    initial begin
        // COOL_CYCLES=3: round-robin window, single-requester in COOL, en low
        //                   en ra rb  a b cool
        tbl.push_back(mk(6'b111_111, 1));
        tbl.push_back(mk(6'b111_101, 1));
        tbl.push_back(mk(6'b111_011, 1));
        tbl.push_back(mk(6'b111_100, 1));
        tbl.push_back(mk(6'b111_111, 2));
        tbl.push_back(mk(6'b101_011, 2));
        tbl.push_back(mk(6'b101_011, 2));
        tbl.push_back(mk(6'b101_010, 2));
        tbl.push_back(mk(6'b101_010, 2));
        tbl.push_back(mk(6'b111_111, 3));
        tbl.push_back(mk(6'b111_011, 3));
        tbl.push_back(mk(6'b111_101, 3));
        tbl.push_back(mk(6'b110_100, 3));
        tbl.push_back(mk(6'b111_111, 4));
        tbl.push_back(mk(6'b011_001, 4));
        tbl.push_back(mk(6'b011_001, 4));
        tbl.push_back(mk(6'b100_000, 4));
        tbl.push_back(mk(6'b111_111, 5));

        pat1 = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};

        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        en = 1'b1; req_a = 1'b1; req_b = 1'b1;
        sel = 3;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #1;
            chk("reset_grants", {30'b0, o_a, o_b}, 32'd0);
            chk("reset_cool", {31'b0, o_cool}, 32'd0);
            chk("reset_dcnt", {24'b0, o_dcnt}, 32'd0);
        end

        sel = 3;
        en = 1'b0; req_a = 1'b0; req_b = 1'b0;
        #2 rst3 = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].ra, tbl[i].rb);
            chk($sformatf("tbl%0d_grant", i), {30'b0, o_a, o_b}, {30'b0, tbl[i].ea, tbl[i].eb});
            chk($sformatf("tbl%0d_cool", i), {31'b0, o_cool}, {31'b0, tbl[i].ecool});
            chk($sformatf("tbl%0d_dcnt", i), {24'b0, o_dcnt}, {24'b0, tbl[i].edcnt});
        end

        // COOL_CYCLES=1, CNT_W=2: alternating pattern and counter saturation
        rst3 = 1'b0;
        sel  = 1;
        #2 rst1 = 1'b1;
        prev_dual = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk_grant($sformatf("c1_pat%0d", i), pat1[i]);
            chk("c1_no_back2back", {31'b0, prev_dual && o_a && o_b}, 32'd0);
            prev_dual = o_a && o_b;
            if (i == 4) chk("c1_dcnt_3duals", {24'b0, o_dcnt}, 32'd3);
        end
        chk("c1_dcnt_saturated", {24'b0, o_dcnt}, 32'd3);

        // COOL_CYCLES=2: window consumed while en is low
        rst1 = 1'b0;
        sel  = 2;
        #2 rst2 = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk_grant("c2_first_dual", 2'b11);
        step(1'b0, 1'b1, 1'b1);
        chk_grant("c2_en_low0", 2'b00);
        chk("c2_en_low0_cool", {31'b0, o_cool}, 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk_grant("c2_en_low1", 2'b00);
        chk("c2_en_low1_cool", {31'b0, o_cool}, 32'd0);
        step(1'b1, 1'b1, 1'b1);
        chk_grant("c2_en_rise_dual", 2'b11);
        chk("c2_dcnt", {24'b0, o_dcnt}, 32'd2);

        // Asynchronous reset in the middle of a DUAL cycle
        #3 rst2 = 1'b0;
        #1;
        chk_grant("async_rst_grants", 2'b00);
        chk("async_rst_dcnt", {24'b0, o_dcnt}, 32'd0);
        chk("async_rst_cool", {31'b0, o_cool}, 32'd0);
        @(posedge clk);
        #2 rst2 = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk_grant("post_rst_dual", 2'b11);
        chk("post_rst_dcnt", {24'b0, o_dcnt}, 32'd1);
        chk("post_rst_cool", {31'b0, o_cool}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
